fifo_rd_fwft_stage: RTL and testbench
=====================================

# fifo_rd_fwft_stage

Read-side first-word-fall-through output stage of the asynchronous FIFO, in the rd_clk domain directly downstream of the read-pointer/empty-flag logic. It issues reads to the FIFO (rd_en) whenever the FIFO is not empty and local space exists, captures the one-cycle-latency synchronous memory read data into a 2-entry skid buffer, and presents it on a registered valid/ready interface. Full throughput is sustained: one word per rd_clk with m_ready held high.

## Interface
- DATA_WIDTH, 8, width of FIFO words.
- rd_clk  in  1  read-domain clock.
- rd_rst_n  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  registered empty flag from the read-pointer block.
- fifo_rd_en  out  1  read request to the pointer block; advances the read pointer.
- fifo_rd_data  in  DATA_WIDTH  memory read data, valid the cycle after fifo_rd_en.
- m_valid  out  1  m_data holds a valid word.
- m_ready  in  1  consumer accepts m_data this cycle.
- m_data  out  DATA_WIDTH  head word, registered.
- level  out  2  buffered words (0..2), excluding in-flight read.
- underrun_cnt  out  8  present only with FIFO_RD_UNDERRUN_CNT_EN.

## Operation
- State: occ (0..2), inflight (1 bit = fifo_rd_en of previous cycle), head/tail data registers.
- pop = m_valid & m_ready.
- fifo_rd_en = rd_rst_n & ~fifo_empty & ((occ + inflight - pop) < 2); combinational, pop look-ahead required for full throughput.
- Next occ = occ + inflight - pop; invariant occ + inflight ≤ 2 at every edge; occ never exceeds 2, no word ever dropped.
- Arrival (inflight=1) writes fifo_rd_data to head if occ==0, or occ==1 with pop; else to tail.
- Pop with occ==2 shifts tail to head in the same edge (arrival then writes tail).
- m_valid = (occ != 0); m_data = head register; level = occ.
- m_data holds stable while m_valid & ~m_ready (AXI-style rules: consumer may not require m_valid to drop).
- fifo_empty high: no read issued; buffered words still drain normally.

## Timing
- Reset (asynchronous): occ=0, inflight=0, m_valid=0, m_data=0, level=0, fifo_rd_en=0, underrun_cnt=0.
- Latency: fifo_empty sampled low in cycle t → fifo_rd_en high in t → data on fifo_rd_data in t+1 → m_valid high in t+2.
- Steady state with m_ready=1 and FIFO non-empty: fifo_rd_en high every cycle, m_valid high every cycle, occ=1, inflight=1.
- m_ready low: reads stop once occ + inflight reaches 2; on m_ready rising, first pop occurs same cycle and fifo_rd_en reasserts same cycle.
- Simultaneous arrival and pop at occ=1: occ stays 1, head replaced by arrival.
- Reset mid-operation: in-flight word discarded; pointer block resets on the same rd_rst_n so state is consistent.

## Configuration
- FIFO_RD_UNDERRUN_CNT_EN defined: port underrun_cnt present; increments each rd_clk with m_ready & ~m_valid; saturates at 255; cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then fifo_empty=1 for 10 cycles → fifo_rd_en=0, m_valid=0, m_data=0, level=0 throughout.
- Preload 8 words 0x10..0x17, m_ready=1 → m_valid rises 2 cycles after fifo_empty falls; 0x10..0x17 delivered on 8 consecutive cycles, no bubbles.
- Same load, m_ready=0 → exactly 2 reads issued, level=2, m_data=0x10 stable; release m_ready → remaining words in order, no loss/duplication.
- Random m_ready toggling (50%) over 1000 words with random fifo_empty gaps → scoreboard in-order match, occ + inflight ≤ 2 every cycle.
- Assert rd_rst_n low with level=2 and inflight=1 → all outputs at reset values immediately; after release, fresh stream from new pointer state delivered correctly.
- With FIFO_RD_UNDERRUN_CNT_EN, m_ready=1 and fifo_empty=1 for 300 cycles → underrun_cnt=255 (saturated).

Source files
------------

// File: rtl/fifo_rd_fwft_stage.sv
// Read-side FWFT output stage: issues FIFO reads and buffers the 1-cycle-latency read data in a 2-entry skid buffer.
// Optional underrun counter via `define FIFO_RD_UNDERRUN_CNT_EN. Latency empty-low to m_valid: 2 cycles; m_ready backpressure stops reads at occ+inflight=2.
module fifo_rd_fwft_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            level
`ifdef FIFO_RD_UNDERRUN_CNT_EN
   ,
   output logic [7:0]            underrun_cnt
`endif
);

   logic [1:0]            occ;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] tail;
   logic                  pop;
   logic [1:0]            occ_next;

   assign pop      = (occ != 2'd0) & m_ready;
   // occ + inflight never exceeds 2, so the post-edge occupancy fits in 2 bits
   assign occ_next = occ + {1'b0, inflight} - {1'b0, pop};

   // Pop look-ahead lets a read issue in the same cycle a word leaves
   assign fifo_rd_en = rd_rst_n & ~fifo_empty & ~occ_next[1];

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         occ      <= 2'd0;
         inflight <= 1'b0;
      end else begin
         occ      <= occ_next;
         inflight <= fifo_rd_en;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (pop && occ == 2'd2)
            head <= tail;
         if (inflight) begin
            if (occ == 2'd0 || (occ == 2'd1 && pop))
               head <= fifo_rd_data;
            else
               tail <= fifo_rd_data;
         end
      end
   end

   assign m_valid = (occ != 2'd0);
   assign m_data  = head;
   assign level   = occ;

`ifdef FIFO_RD_UNDERRUN_CNT_EN
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n)
         underrun_cnt <= 8'd0;
      else if (m_ready && !m_valid && underrun_cnt != 8'hFF)
         underrun_cnt <= underrun_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// Directed + random bench for fifo_rd_fwft_stage with a behavioural read-pointer/memory model and in-order scoreboard.
module tb_fifo_rd_fwft_stage;

   logic       rd_clk = 1'b0;
   logic       rd_rst_n = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       fifo_rd_en;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic [1:0] level;
`ifdef FIFO_RD_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt;
`endif

   fifo_rd_fwft_stage #(.DATA_WIDTH(8)) dut (
      .rd_clk       (rd_clk),
      .rd_rst_n     (rd_rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .level        (level)
`ifdef FIFO_RD_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 rd_clk = ~rd_clk;

   logic [7:0] mem [0:4095];
   int         rd_ptr = 0;
   int         avail = 0;
   bit         last_en = 1'b0;
   logic [7:0] exp_q [$];
   int         total = 0;
   int         bad = 0;
   int         delivered = 0;
   int         reads = 0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       s_valid, s_en;
   logic [7:0] s_data;
   logic [1:0] s_level;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Make n words available in the FIFO; each becomes an expected output
   task automatic load(input int n, input int base, input bit rnd);
      for (int i = 0; i < n; i++) begin
         mem[avail % 4096] = rnd ? 8'($urandom) : 8'(base + i);
         exp_q.push_back(mem[avail % 4096]);
         avail++;
      end
   endtask

   // One rd_clk cycle; entered and left 1 time unit after a rising edge
   task automatic cyc(input bit rdy);
      if (last_en) begin
         fifo_rd_data = mem[rd_ptr % 4096];
         rd_ptr++;
      end
      fifo_empty = (rd_ptr >= avail);
      m_ready = rdy;
      #1;
      s_valid = m_valid; s_data = m_data; s_level = level; s_en = fifo_rd_en;
      chk("occ_plus_inflight", 32'((32'(level) + 32'(last_en)) <= 2), 32'd1);
      if (prev_stall) begin
         chk("hold_valid", 32'(m_valid), 32'd1);
         chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0)
            chk("spurious_word", 32'(m_valid), 32'd0);
         else
            chk("order", 32'(m_data), 32'(exp_q.pop_front()));
         delivered++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_data = m_data;
      last_en = fifo_rd_en;
      if (fifo_rd_en) reads++;
      @(posedge rd_clk);
      #1;
   endtask

   initial begin
      int target;
      int loaded;
      int n;

      // Reset state
      #12;
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
`ifdef FIFO_RD_UNDERRUN_CNT_EN
      chk("rst_underrun", 32'(underrun_cnt), 32'd0);
`endif
      @(posedge rd_clk); #1;
      rd_rst_n = 1'b1;

      // Empty FIFO: nothing issued, nothing presented
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1);
         chk("idle_rd_en", 32'(s_en), 32'd0);
         chk("idle_valid", 32'(s_valid), 32'd0);
         chk("idle_data", 32'(s_data), 32'd0);
         chk("idle_level", 32'(s_level), 32'd0);
      end

      // Full-throughput stream of 0x10..0x17
      load(8, 'h10, 1'b0);
      cyc(1'b1);
      chk("lat_rd_en_t", 32'(s_en), 32'd1);
      chk("lat_valid_t", 32'(s_valid), 32'd0);
      cyc(1'b1);
      chk("lat_valid_t1", 32'(s_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1);
         chk("stream_valid", 32'(s_valid), 32'd1);
         chk("stream_data", 32'(s_data), 32'('h10 + i));
      end
      cyc(1'b1);
      chk("stream_end_valid", 32'(s_valid), 32'd0);
      chk("stream_left", 32'(exp_q.size()), 32'd0);

      // Backpressure: only two reads, head held
      reads = 0;
      load(8, 'h20, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0);
      chk("bp_reads", 32'(reads), 32'd2);
      chk("bp_level", 32'(s_level), 32'd2);
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_data", 32'(s_data), 32'h20);
      cyc(1'b1);
      chk("bp_release_rd_en", 32'(s_en), 32'd1);
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) cyc(1'b1);
      chk("bp_drain", 32'(exp_q.size()), 32'd0);

      // Random ready and random FIFO fill gaps
      target = delivered + 1000;
      loaded = 0;
      for (int i = 0; i < 30000 && delivered < target; i++) begin
         if (loaded < 1000 && $urandom_range(0, 7) == 0) begin
            n = $urandom_range(1, 6);
            if (n > 1000 - loaded) n = 1000 - loaded;
            load(n, 0, 1'b1);
            loaded += n;
         end
         cyc(1'($urandom_range(0, 1)));
      end
      chk("rand_delivered", 32'(delivered), 32'(target));
      chk("rand_left", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset with a buffered word and a read in flight
      load(6, 'h40, 1'b0);
      cyc(1'b0);
      cyc(1'b0);
      chk("pre_rst_level", 32'(level), 32'd1);
      chk("pre_rst_inflight", 32'(last_en), 32'd1);
      #2;
      rd_rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      chk("mid_rst_data", 32'(m_data), 32'd0);
      chk("mid_rst_level", 32'(level), 32'd0);
`ifdef FIFO_RD_UNDERRUN_CNT_EN
      chk("mid_rst_underrun", 32'(underrun_cnt), 32'd0);
`endif
      rd_ptr = 2000;
      avail = 2000;
      exp_q.delete();
      last_en = 1'b0;
      prev_stall = 1'b0;
      fifo_empty = 1'b1;
      @(posedge rd_clk); #1;
      rd_rst_n = 1'b1;
      load(5, 'h50, 1'b0);
      target = delivered + 5;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b1);
      chk("post_rst_drain", 32'(exp_q.size()), 32'd0);
      chk("post_rst_count", 32'(delivered), 32'(target));

`ifdef FIFO_RD_UNDERRUN_CNT_EN
      for (int i = 0; i < 300; i++) cyc(1'b1);
      chk("underrun_sat", 32'(underrun_cnt), 32'd255);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
